// File: rtl/psum_accum.sv
// Output-stationary psum accumulator: folds 9x36 OFIFO rows into a 4x4 output tile, then drains it.
// Optional build macro PSUM_ACCUM_RELU_EN clamps negative output lanes to zero on the way out.
module psum_accum #(
   parameter int COL     = 8,
   parameter int PSUM_BW = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COL*PSUM_BW-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COL*PSUM_BW-1:0] out_data,
   output logic                   busy,
   output logic                   done
);

   localparam int ROW_W = COL * PSUM_BW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   // nij and kij are kept as (row, col) pairs so the index map needs no divider.
   logic [2:0] a_r_q, a_r_d, a_c_q, a_c_d;
   logic [1:0] k_r_q, k_r_d, k_c_q, k_c_d;
   logic [3:0] o_cnt_q, o_cnt_d;

   logic [ROW_W-1:0] acc_q [16];

   logic             in_hs_s, out_hs_s, hit_s, first_s;
   logic [3:0]       r_s, c_s, idx_s;
   logic [ROW_W-1:0] sum_s;

   function automatic logic [ROW_W-1:0] shape_row(input logic [ROW_W-1:0] x);
      logic [ROW_W-1:0] y;
      y = x;
`ifdef PSUM_ACCUM_RELU_EN
      for (int l = 0; l < COL; l++) begin
         if (x[l*PSUM_BW + PSUM_BW - 1]) begin
            y[l*PSUM_BW +: PSUM_BW] = '0;
         end else begin
            y[l*PSUM_BW +: PSUM_BW] = x[l*PSUM_BW +: PSUM_BW];
         end
      end
`endif
      return y;
   endfunction

   // Next-state logic for the tile FSM and its counters.
   always_comb begin
      state_d  = state_q;
      a_r_d    = a_r_q;
      a_c_d    = a_c_q;
      k_r_d    = k_r_q;
      k_c_d    = k_c_q;
      o_cnt_d  = o_cnt_q;
      in_hs_s  = in_valid && (state_q == S_ACCUM);
      out_hs_s = out_ready && (state_q == S_DRAIN);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               a_r_d   = 3'd0;
               a_c_d   = 3'd0;
               k_r_d   = 2'd0;
               k_c_d   = 2'd0;
               o_cnt_d = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (in_hs_s) begin
               if (a_c_q != 3'd5) begin
                  a_c_d = a_c_q + 3'd1;
               end else begin
                  a_c_d = 3'd0;
                  if (a_r_q != 3'd5) begin
                     a_r_d = a_r_q + 3'd1;
                  end else begin
                     a_r_d = 3'd0;
                     if (k_c_q != 2'd2) begin
                        k_c_d = k_c_q + 2'd1;
                     end else begin
                        k_c_d = 2'd0;
                        if (k_r_q != 2'd2) begin
                           k_r_d = k_r_q + 2'd1;
                        end else begin
                           k_r_d   = 2'd0;
                           state_d = S_DRAIN;
                        end
                     end
                  end
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_DRAIN: begin
            if (out_hs_s) begin
               if (o_cnt_q == 4'd15) begin
                  o_cnt_d = 4'd0;
                  state_d = S_DONE;
               end else begin
                  o_cnt_d = o_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output coordinate of the current row; negative or >=4 values fall outside 0..3 in 4-bit form.
   always_comb begin
      r_s     = {1'b0, a_r_q} - {2'b00, k_r_q};
      c_s     = {1'b0, a_c_q} - {2'b00, k_c_q};
      idx_s   = {r_s[1:0], c_s[1:0]};
      hit_s   = in_hs_s && (r_s[3:2] == 2'b00) && (c_s[3:2] == 2'b00);
      first_s = (k_r_q == 2'd0) && (k_c_q == 2'd0);
      sum_s   = '0;
      for (int l = 0; l < COL; l++) begin
         if (first_s) begin
            sum_s[l*PSUM_BW +: PSUM_BW] = in_data[l*PSUM_BW +: PSUM_BW];
         end else begin
            sum_s[l*PSUM_BW +: PSUM_BW] = acc_q[idx_s][l*PSUM_BW +: PSUM_BW]
                                        + in_data[l*PSUM_BW +: PSUM_BW];
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_r_q   <= 3'd0;
         a_c_q   <= 3'd0;
         k_r_q   <= 2'd0;
         k_c_q   <= 2'd0;
         o_cnt_q <= 4'd0;
      end else begin
         state_q <= state_d;
         a_r_q   <= a_r_d;
         a_c_q   <= a_c_d;
         k_r_q   <= k_r_d;
         k_c_q   <= k_c_d;
         o_cnt_q <= o_cnt_d;
      end
   end

   // Accumulation buffer; the kij=0 pass overwrites, so it never needs clearing.
   always_ff @(posedge clk) begin
      if (hit_s) begin
         acc_q[idx_s] <= sum_s;
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      in_ready  = (state_q == S_ACCUM);
      out_valid = (state_q == S_DRAIN);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      if (state_q == S_DRAIN) begin
         out_data = shape_row(acc_q[o_cnt_q]);
      end else begin
         out_data = '0;
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed tiles plus random data/stalls against a conv model.
module tb_psum_accum;

   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int W   = COL * BW;

   logic         clk = 1'b0;
   logic         reset, start, in_valid, out_ready;
   logic         in_ready, out_valid, busy, done;
   logic [W-1:0] in_data, out_data;

   psum_accum #(.COL(COL), .PSUM_BW(BW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] rows [9][36];
   logic [W-1:0] exp_row [16];
   int           cyc;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // mode 0 ones, 1 single, 2 negative lane 3, 3 wrap lane 0, 4 random
   task automatic gen_rows(input int mode);
      for (int k = 0; k < 9; k++) begin
         for (int n = 0; n < 36; n++) begin
            logic [W-1:0] v;
            v = '0;
            for (int l = 0; l < COL; l++) begin
               case (mode)
                  0: v[l*BW +: BW] = 16'h0001;
                  1: v[l*BW +: BW] = (k == 4 && n == 7 && l == 0) ? 16'h0005 : 16'h0000;
                  2: v[l*BW +: BW] = (l == 3) ? 16'hFFFE : 16'h0001;
                  3: v[l*BW +: BW] = (l == 0) ? 16'h7FFF : 16'h0000;
                  default: v[l*BW +: BW] = 16'($urandom);
               endcase
            end
            rows[k][n] = v;
         end
      end
   endtask

   // Golden model: out(r,c) = sum over kernel (kr,kc) of the row at padded position (r+kr, c+kc).
   task automatic model();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            logic [W-1:0] v;
            for (int l = 0; l < COL; l++) begin
               logic [BW-1:0] s;
               s = '0;
               for (int kr = 0; kr < 3; kr++)
                  for (int kc = 0; kc < 3; kc++)
                     s = s + rows[kr*3+kc][(r+kr)*6 + (c+kc)][l*BW +: BW];
`ifdef PSUM_ACCUM_RELU_EN
               if (s[BW-1]) s = '0;
`endif
               v[l*BW +: BW] = s;
            end
            exp_row[r*4+c] = v;
         end
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in_ready"},  W'(in_ready),  W'(0));
      chk({tag, "_out_valid"}, W'(out_valid), W'(0));
      chk({tag, "_out_data"},  out_data,      W'(0));
      chk({tag, "_busy"},      W'(busy),      W'(0));
      chk({tag, "_done"},      W'(done),      W'(0));
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      chk("start_in_ready", W'(in_ready), W'(1));
   endtask

   // Feeds rows up to (not including) kij stop_k; stop_k = 9 feeds the whole tile.
   task automatic feed(input int in_gap, input int stop_k);
      int k, n, budget;
      logic hs;
      k = 0; n = 0; budget = 0;
      while (k < stop_k) begin
         in_valid = ($urandom_range(0, 99) >= in_gap);
         in_data  = in_valid ? rows[k][n] : {$urandom, $urandom, $urandom, $urandom};
         start    = $urandom_range(0, 7) == 0;
         hs       = in_valid && in_ready;
         if (n == 0 && k == 0) chk("accum_out_zero", out_data, W'(0));
         @(posedge clk); #1;
         cyc++; budget++;
         if (hs) begin
            n++;
            if (n == 36) begin n = 0; k++; end
         end
         if (budget > 5000) begin
            chk("feed_timeout", W'(1), W'(0));
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic drain(input int out_gap, input bit check_len);
      int o, budget;
      logic hs;
      logic [W-1:0] held;
      o = 0; budget = 0;
      chk("drain_first_valid", W'(out_valid), W'(1));
      while (o < 16) begin
         out_ready = ($urandom_range(0, 99) >= out_gap);
         in_valid  = $urandom_range(0, 1) == 1;
         start     = $urandom_range(0, 3) == 0;
         chk($sformatf("out_row%0d", o), out_data, exp_row[o]);
         hs   = out_ready && out_valid;
         held = out_data;
         @(posedge clk); #1;
         cyc++; budget++;
         if (hs) o++;
         else if (out_valid) chk("stall_hold", out_data, held);
         if (budget > 5000) begin
            chk("drain_timeout", W'(1), W'(0));
            break;
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      chk("done_pulse", W'(done), W'(1));
      chk("done_busy",  W'(busy), W'(1));
      if (check_len) chk("done_latency", W'(cyc), W'(340));
      @(posedge clk); #1;
      chk_idle_outputs("after_done");
   endtask

   task automatic run_tile(input int mode, input int in_gap, input int out_gap);
      gen_rows(mode);
      model();
      kick();
      feed(in_gap, 9);
      drain(out_gap, (in_gap == 0) && (out_gap == 0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #1;
      chk_idle_outputs("reset");
      @(posedge clk); #3;
      reset = 1'b0;
      @(posedge clk); #1;
      chk_idle_outputs("idle");

      // All-ones tile, no stalls
      run_tile(0, 0, 0);
      chk("ones_lanes", exp_row[7], {COL{16'h0009}});
      // Single contribution
      run_tile(1, 0, 0);
      chk("single_row0", exp_row[0], {{(COL-1){16'h0000}}, 16'h0005});
      // Negative sums
      run_tile(2, 0, 0);
`ifdef PSUM_ACCUM_RELU_EN
      chk("neg_lane3", W'(exp_row[5][3*BW +: BW]), W'(16'h0000));
`else
      chk("neg_lane3", W'(exp_row[5][3*BW +: BW]), W'(16'hFFEE));
`endif
      // Wrap-around without saturation
      run_tile(3, 0, 0);
      chk("wrap_lane0", W'(exp_row[9][BW-1:0]), W'(16'h7FF7));
      // Random data with stalls on both sides
      run_tile(4, 30, 30);
      run_tile(4, 60, 10);

      // Reset mid-tile during kij = 5
      gen_rows(4);
      kick();
      feed(20, 5);
      in_valid = 1'b1;
      in_data  = rows[5][0];
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk_idle_outputs("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk_idle_outputs("post_reset_idle");
      in_valid = 1'b0;
      run_tile(4, 0, 0);
      run_tile(4, 25, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
